// File: rtl/cic_pkg.sv
// Shared CIC constants and width helpers.
// Widths are compile-time functions of the input width and rate-change factor.
package cic_pkg;

    localparam int CIC_ORDER = 3;

    function automatic int cic_int_width(input int width, input int m);
        return width + $clog2(m ** 3);
    endfunction

    function automatic int cic_interp_out_width(input int width, input int m);
        return width + $clog2(m ** 2);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator (differential delay 1): out <= in - in_prev.
// Updates only when en is high; otherwise holds. Arithmetic wraps modulo 2**W.
module cic_comb_stage #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    logic [W-1:0] dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
            dly <= '0;
        end else if (en) begin
            out <= in - dly;
            dly <= in;
        end
    end

endmodule

// File: rtl/cic_3_interpolator.sv
// Order-3 interpolating CIC: combs at the input rate, zero-stuff, integrators at the strobe rate.
// Input accepted only on phase-0 strobes with no buffering; a missing sample is taken as 0 and flagged.
module cic_3_interpolator
    import cic_pkg::*;
#(
    parameter int M     = 4,
    parameter int width = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     out_stb,
    input  logic [width-1:0]                         in_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic [cic_interp_out_width(width, M)-1:0] out,
    output logic                                     out_valid,
    output logic                                     underrun
);

    localparam int W  = cic_int_width(width, M);
    localparam int OW = cic_interp_out_width(width, M);
    localparam int PW = $clog2(M);

    logic [PW-1:0]                  phase;
    logic                           phase0;
    logic                           load;
    logic [W-1:0]                   x;
    logic [CIC_ORDER:0][W-1:0]      comb_q;
    logic                           first_q;
    logic [W-1:0]                   u;
    logic [W-1:0]                   i0;
    logic [W-1:0]                   i1;
    logic [OW-1:0]                  i2;

    assign phase0   = (phase == '0);
    assign load     = out_stb && phase0 && !reset;
    assign in_ready = load;

    // A phase-0 strobe without a valid sample feeds a zero into the combs.
    assign x = in_valid ? {{(W - width){in_data[width-1]}}, in_data} : '0;

    assign comb_q[0] = x;

    for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
        cic_comb_stage #(
            .W(W)
        ) u_comb (
            .clk  (clk),
            .reset(reset),
            .en   (load),
            .in   (comb_q[g]),
            .out  (comb_q[g+1])
        );
    end

    // Zero-stuffing: the comb output enters the integrators on the strobe after phase 0 only.
    assign u = first_q ? comb_q[CIC_ORDER] : '0;

    // The last integrator keeps only the output bits; the wrap makes the upper bits irrelevant.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= '0;
            first_q   <= 1'b0;
            i0        <= '0;
            i1        <= '0;
            i2        <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            out_valid <= out_stb;
            if (out_stb) begin
                if (phase == PW'(M - 1)) begin
                    phase <= '0;
                end else begin
                    phase <= phase + PW'(1);
                end
                first_q <= phase0;
                i0      <= i0 + u;
                i1      <= i1 + i0;
                i2      <= i2 + i1[OW-1:0];
                if (phase0 && !in_valid) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    assign out = i2;

endmodule

// File: tb/tb_cic_3_interpolator.sv
// Directed and random checks of the interpolating CIC (M=4 and M=8) against a convolution model.
module tb_cic_3_interpolator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stb4 = 1'b0;
    logic        stb8 = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready4, in_ready8;
    logic        out_valid4, out_valid8;
    logic        underrun4, underrun8;
    logic [19:0] out4;
    logic [21:0] out8;

    always #5 clk = ~clk;

    cic_3_interpolator #(.M(4), .width(16)) dut4 (
        .clk(clk), .reset(reset), .out_stb(stb4), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready4), .out(out4), .out_valid(out_valid4), .underrun(underrun4)
    );

    cic_3_interpolator #(.M(8), .width(16)) dut8 (
        .clk(clk), .reset(reset), .out_stb(stb8), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready8), .out(out8), .out_valid(out_valid8), .underrun(underrun8)
    );

    int     checks = 0;
    int     errors = 0;
    int     xs[$];          // low-rate samples as the filter saw them (underruns as 0)
    int     s_cnt;          // strobe edges since reset
    bit     ur_model;
    longint obs_q[$];       // out after each strobe edge

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tap k of the cascade of three length-m boxcars: number of (a,b,c) in [0,m) with a+b+c=k.
    function automatic longint taps(input int m, input int k);
        longint n = 0;
        for (int a = 0; a < m; a++)
            for (int b = 0; b < m; b++)
                if (k - a - b >= 0 && k - a - b < m) n++;
        return n;
    endfunction

    // Output after strobe edge e: zero-stuffed input convolved with the taps, delayed 2M+3, wrapped.
    function automatic longint model(input int m, input int e);
        int     ow = 16 + $clog2(m * m);
        int     n = e - (2 * m + 3);
        longint acc = 0;
        if (n < 0) return 0;
        for (int k = 0; k <= 3 * m - 3; k++) begin
            int t = n - k;
            if (t >= 0 && (t % m) == 0 && (t / m) < xs.size())
                acc += taps(m, k) * longint'(xs[t / m]);
        end
        acc = (acc <<< (64 - ow)) >>> (64 - ow);
        return acc;
    endfunction

    function automatic longint dut_out(input int m);
        return (m == 4) ? longint'($signed(out4)) : longint'($signed(out8));
    endfunction
    function automatic longint dut_rdy(input int m);
        return (m == 4) ? longint'(in_ready4) : longint'(in_ready8);
    endfunction
    function automatic longint dut_ov(input int m);
        return (m == 4) ? longint'(out_valid4) : longint'(out_valid8);
    endfunction
    function automatic longint dut_ur(input int m);
        return (m == 4) ? longint'(underrun4) : longint'(underrun8);
    endfunction

    function automatic int rnd16();
        logic [15:0] r = 16'($urandom);
        return int'($signed(r));
    endfunction

    task automatic strobe(input int m, input bit v, input int d);
        @(negedge clk);
        stb4 = (m == 4);
        stb8 = (m == 8);
        in_valid = v;
        in_data = 16'(d);
        #1;
        chk("in_ready_strobe", dut_rdy(m), longint'(s_cnt % m == 0));
        if (s_cnt % m == 0) begin
            xs.push_back(v ? d : 0);
            if (!v) ur_model = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("out_valid_after_strobe", dut_ov(m), 1);
        chk("out", dut_out(m), model(m, s_cnt));
        chk("underrun", dut_ur(m), longint'(ur_model));
        obs_q.push_back(dut_out(m));
        s_cnt++;
    endtask

    task automatic idle(input int m, input int n);
        repeat (n) begin
            @(negedge clk);
            stb4 = 1'b0;
            stb8 = 1'b0;
            #1;
            chk("in_ready_idle", dut_rdy(m), 0);
            @(posedge clk);
            #1;
            chk("out_valid_idle", dut_ov(m), 0);
            chk("out_hold", dut_out(m), model(m, s_cnt - 1));
        end
    endtask

    // One low-rate sample spread over m strobes; v=0 drops it at the phase-0 strobe.
    task automatic feed(input int m, input int d, input bit v, input int gap);
        for (int p = 0; p < m; p++) begin
            strobe(m, (p == 0) ? v : 1'b1, d);
            if (gap > 0) idle(m, gap);
        end
    endtask

    task automatic do_reset(input bit with_stb);
        @(negedge clk);
        reset = 1'b1;
        stb4 = with_stb;
        stb8 = with_stb;
        in_valid = 1'b1;
        #1;
        chk("in_ready4_in_reset", longint'(in_ready4), 0);
        chk("in_ready8_in_reset", longint'(in_ready8), 0);
        @(posedge clk);
        #1;
        chk("reset_out4", longint'(out4), 0);
        chk("reset_out8", longint'(out8), 0);
        chk("reset_out_valid4", longint'(out_valid4), 0);
        chk("reset_out_valid8", longint'(out_valid8), 0);
        chk("reset_underrun4", longint'(underrun4), 0);
        chk("reset_underrun8", longint'(underrun8), 0);
        @(negedge clk);
        reset = 1'b0;
        stb4 = 1'b0;
        stb8 = 1'b0;
        xs.delete();
        obs_q.delete();
        s_cnt = 0;
        ur_model = 1'b0;
    endtask

    task automatic check_impulse(input string tag);
        longint h[10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
        chk({tag, "_pre"}, obs_q[10], 0);
        for (int j = 0; j < 10; j++) chk({tag, "_tap"}, obs_q[11 + j], h[j]);
        for (int j = 21; j < 32; j++) chk({tag, "_tail"}, obs_q[j], 0);
    endtask

    initial begin
        int     rnd[24];
        longint dense[$];

        // Reset state, then the M=4 impulse response with back-to-back strobes.
        do_reset(1'b0);
        for (int j = 0; j < 16; j++) feed(4, (j == 0) ? 1 : 0, 1'b1, 0);
        idle(4, 1);
        check_impulse("impulse");

        // Reset coinciding with a strobe, then DC settling at gain M**2.
        do_reset(1'b1);
        for (int j = 0; j < 40; j++) feed(4, 100, 1'b1, 0);
        idle(4, 1);
        for (int j = 140; j < 160; j++) chk("dc_settled", obs_q[j], 1600);

        // Random dense run with one dropped sample.
        for (int j = 0; j < 24; j++) rnd[j] = rnd16();
        do_reset(1'b0);
        for (int j = 0; j < 24; j++) feed(4, rnd[j], (j != 10), 0);
        idle(4, 1);
        chk("underrun_sticky", dut_ur(4), 1);
        dense = obs_q;

        // Same sequence with a strobe every third clock must give identical samples.
        do_reset(1'b0);
        for (int j = 0; j < 24; j++) feed(4, rnd[j], (j != 10), 2);
        chk("sparse_len", longint'(obs_q.size()), longint'(dense.size()));
        for (int j = 0; j < dense.size() && j < obs_q.size(); j++)
            chk("sparse_vs_dense", obs_q[j], dense[j]);

        // Reset mid-stream after 20 inputs, then the impulse must come out clean.
        do_reset(1'b0);
        for (int j = 0; j < 20; j++) feed(4, rnd16(), 1'b1, 0);
        do_reset(1'b0);
        for (int j = 0; j < 16; j++) feed(4, (j == 0) ? 1 : 0, 1'b1, 0);
        idle(4, 1);
        check_impulse("impulse_after_reset");

        // Full-scale square wave at M=8 exercises the internal wrap.
        do_reset(1'b0);
        for (int j = 0; j < 30; j++) feed(8, (j % 2 == 0) ? 32767 : -32767, 1'b1, 0);
        idle(8, 2);
        chk("square_no_underrun", dut_ur(8), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
